// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter and sequencer for the single-ported data memory
//
// Shares one data memory between the CPU MEM stage (port A) and a debug/loader
// port (port B). Each granted transaction holds the memory strobe for
// WAIT_CYCLES cycles, then returns a one-cycle ready pulse. Out-of-range or
// misaligned addresses complete one cycle after the grant with ready+err and no
// memory strobe.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata  port A (CPU) request
//   a_rdata/a_ready/a_err      port A response (rdata registered)
//   b_*                        same for port B (debug/loader)
//   freeze                     pipeline stall while a CPU access is outstanding
//   mem_r_en/mem_w_en          memory strobes
//   mem_addr/mem_wdata         memory byte address / write data
//   mem_rdata                  memory read data (combinational from mem_addr)
//
// Optional: define DMEM_ARB_STATS_EN to add a_stall_cnt and b_wait_cnt
// saturating 16-bit statistics outputs.
module dmem_arbiter #(
    parameter int DATA_W      = 32,
    parameter int BASE_ADDR   = 1024,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [DATA_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_ready,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [DATA_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_ready,
    output logic              b_err,
    output logic              freeze,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]       a_stall_cnt,
    output logic [15:0]       b_wait_cnt,
`endif
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [DATA_W-1:0] BASE     = DATA_W'(BASE_ADDR);
    localparam logic [DATA_W-1:0] SPAN     = DATA_W'(4 * DEPTH);
    localparam logic [3:0]        CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_b;     // last grant went to port B
    logic              sel_b;      // port currently in service is B
    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        cnt;

    // Grant decision, only acted on in IDLE. On a tie the port that did not
    // win last time gets the memory.
    logic              pick_a;
    logic              pick_b;
    logic              grant;
    logic              req_we;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] req_off;
    logic              addr_ok;

    assign pick_a    = a_req & (~b_req | last_b);
    assign pick_b    = b_req & ~pick_a;
    assign grant     = pick_a | pick_b;
    assign req_we    = pick_b ? b_we    : a_we;
    assign req_addr  = pick_b ? b_addr  : a_addr;
    assign req_wdata = pick_b ? b_wdata : a_wdata;
    // Unsigned subtraction: addresses below BASE wrap to huge offsets and
    // therefore fail the range check as well.
    assign req_off   = req_addr - BASE;
    assign addr_ok   = (req_off < SPAN) && (req_addr[1:0] == 2'b00);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = addr_ok ? ACCESS : ERR;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state; an asynchronous reset drops the strobes
    // immediately because the state register clears without a clock.
    always_comb begin
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        a_ready  = 1'b0;
        a_err    = 1'b0;
        b_ready  = 1'b0;
        b_err    = 1'b0;
        case (state)
            ACCESS: begin
                mem_r_en = ~we_q;
                mem_w_en = we_q;
            end
            DONE: begin
                a_ready = ~sel_b;
                b_ready = sel_b;
            end
            ERR: begin
                a_ready = ~sel_b;
                a_err   = ~sel_b;
                b_ready = sel_b;
                b_err   = sel_b;
            end
            default: ;
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign freeze    = a_req & ~a_ready;

    // Request latch, wait counter and read-data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b  <= 1'b1;
            sel_b   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= 4'd0;
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        last_b  <= pick_b;
                        sel_b   <= pick_b;
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt     <= CNT_INIT;
                        // Rejected access: rdata reads 0 during the err pulse.
                        if (!addr_ok) begin
                            if (pick_b) begin
                                b_rdata <= '0;
                            end else begin
                                a_rdata <= '0;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!we_q) begin
                            if (sel_b) begin
                                b_rdata <= mem_rdata;
                            end else begin
                                a_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    // B is waiting when it requests but is neither being granted this cycle
    // nor already the port in service.
    logic b_served;
    assign b_served = ((state == IDLE) & pick_b) | ((state != IDLE) & sel_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_stall_cnt <= 16'd0;
            b_wait_cnt  <= 16'd0;
        end else begin
            if (freeze && a_stall_cnt != 16'hFFFF) begin
                a_stall_cnt <= a_stall_cnt + 16'd1;
            end
            if (b_req && !b_served && b_wait_cnt != 16'hFFFF) begin
                b_wait_cnt <= b_wait_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int WAIT = 2;
    localparam int BASE = 1024;
    localparam int DEP  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
    logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        a_ready, a_err, b_ready, b_err, freeze, mem_r_en, mem_w_en;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] a_stall_cnt, b_wait_cnt;
`endif

    int checks = 0;
    int failures = 0;

    // Memory behind the arbiter, and the bench's own expected contents.
    logic [31:0] env_mem [DEP];
    logic [31:0] ref_mem [DEP];
    logic [31:0] last_rd_a = '0;
    logic [31:0] last_rd_b = '0;
    logic [31:0] mem_off;

    assign mem_off   = mem_addr - 32'(BASE);
    assign mem_rdata = env_mem[mem_off[7:2]];

    always @(posedge clk) begin
        if (mem_w_en) env_mem[mem_off[7:2]] <= mem_wdata;
    end

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(32), .BASE_ADDR(BASE), .DEPTH(DEP), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ready(a_ready), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ready(b_ready), .b_err(b_err),
        .freeze(freeze),
`ifdef DMEM_ARB_STATS_EN
        .a_stall_cnt(a_stall_cnt), .b_wait_cnt(b_wait_cnt),
`endif
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_err(input logic [31:0] addr);
        return !(addr >= 32'(BASE) && addr <= 32'(BASE + 4 * DEP - 1)) || (addr % 4 != 0);
    endfunction

    // One transaction on one port, started at a negedge while the arbiter is idle.
    task automatic do_txn(input bit port_b, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
        bit          err_e, seen;
        int          lat_e, cyc, strobes, wrong, other;
        logic [31:0] rd_e;
        err_e = exp_err(addr);
        lat_e = err_e ? 1 : WAIT + 1;
        if (err_e)    rd_e = '0;
        else if (!we) rd_e = ref_mem[(addr - BASE) / 4];
        else          rd_e = port_b ? last_rd_b : last_rd_a;
        if (port_b) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
        end
        #1;
        if (!port_b) check({tag, "_freeze_start"}, 32'(freeze), 32'd1);
        cyc = 0; strobes = 0; wrong = 0; other = 0; seen = 1'b0;
        while (!seen && cyc < 30) begin
            @(posedge clk); @(negedge clk); cyc++;
            if (mem_w_en || mem_r_en) begin
                strobes++;
                if (mem_addr !== addr || mem_w_en !== we || mem_r_en !== !we ||
                    (we && mem_wdata !== wdata)) wrong++;
            end
            if (port_b ? a_ready : b_ready) other++;
            if (port_b ? b_ready : a_ready) seen = 1'b1;
        end
        check({tag, "_ready_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(lat_e));
        check({tag, "_err"}, 32'(port_b ? b_err : a_err), 32'(err_e));
        check({tag, "_rdata"}, port_b ? b_rdata : a_rdata, rd_e);
        check({tag, "_strobes"}, 32'(strobes), err_e ? 32'd0 : 32'(WAIT));
        check({tag, "_strobe_fields"}, 32'(wrong), 32'd0);
        check({tag, "_other_ready"}, 32'(other), 32'd0);
        if (!port_b) check({tag, "_freeze_at_ready"}, 32'(freeze), 32'd0);
        if (!err_e && we) ref_mem[(addr - BASE) / 4] = wdata;
        if (port_b) begin
            last_rd_b = rd_e; b_req = 1'b0;
        end else begin
            last_rd_a = rd_e; a_req = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        check({tag, "_ready_cleared"}, 32'(a_ready | b_ready), 32'd0);
    endtask

    initial begin
        int          cyc, n_rdy;
        logic [31:0] addr, data;
        bit          pb, we;
        for (int i = 0; i < DEP; i++) begin
            env_mem[i] = 32'(i) * 32'h0101_0101 + 32'h1357_0000;
            ref_mem[i] = env_mem[i];
        end

        // Reset state
        #1;
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd0);
        check("rst_errs", 32'({a_err, b_err}), 32'd0);
        check("rst_strobes", 32'({mem_r_en, mem_w_en}), 32'd0);
        check("rst_a_rdata", a_rdata, 32'd0);
        check("rst_b_rdata", b_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Both ports read from reset with requests held: A,B,A,B,A every WAIT+2 cycles.
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'(BASE + 4);
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'(BASE + 8);
        cyc = 0; n_rdy = 0;
        while (n_rdy < 5 && cyc < 40) begin
            @(posedge clk); @(negedge clk); cyc++;
`ifdef DMEM_ARB_STATS_EN
            if (cyc == WAIT + 2) begin
                check("stats_b_wait", 32'(b_wait_cnt), 32'd4);
                check("stats_a_stall", 32'(a_stall_cnt), 32'd3);
            end
`endif
            if (a_ready || b_ready) begin
                check($sformatf("arb_port_%0d", n_rdy), 32'({a_ready, b_ready}),
                      (n_rdy % 2 == 0) ? 32'd2 : 32'd1);
                check($sformatf("arb_cycle_%0d", n_rdy), 32'(cyc), 32'((n_rdy + 1) * (WAIT + 2) - 1));
                if (a_ready) check("arb_a_rdata", a_rdata, ref_mem[1]);
                if (b_ready) check("arb_b_rdata", b_rdata, ref_mem[2]);
                n_rdy++;
            end
        end
        check("arb_count", 32'(n_rdy), 32'd5);
        a_req = 1'b0; b_req = 1'b0;
        last_rd_a = ref_mem[1]; last_rd_b = ref_mem[2];
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);

        // Directed write/read and the address boundaries
        do_txn(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, "wr1024");
        do_txn(1'b0, 1'b0, 32'd1024, 32'h0, "rd1024");
        do_txn(1'b0, 1'b0, 32'd1023, 32'h0, "rd1023");
        do_txn(1'b0, 1'b0, 32'd1280, 32'h0, "rd1280");
        do_txn(1'b0, 1'b0, 32'd1026, 32'h0, "rd1026");
        do_txn(1'b0, 1'b0, 32'd1276, 32'h0, "rd1276");
        do_txn(1'b1, 1'b1, 32'd1276, 32'hCAFE_F00D, "b_wr1276");
        do_txn(1'b1, 1'b0, 32'd1276, 32'h0, "b_rd1276");

        // Reset during the second ACCESS cycle of a write
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'(BASE + 40); a_wdata = 32'h0BAD_CAFE;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("abort_strobe_before", 32'(mem_w_en), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_strobe_drop", 32'(mem_w_en), 32'd0);
        check("abort_no_ready", 32'(a_ready), 32'd0);
        a_req = 1'b0;
        @(posedge clk); @(negedge clk);
        check("abort_no_ready_later", 32'(a_ready), 32'd0);
        rst = 1'b0;
        // The first strobed edge already wrote the memory; reset cleared rdata.
        ref_mem[10] = 32'h0BAD_CAFE;
        last_rd_a = '0; last_rd_b = '0;
        do_txn(1'b0, 1'b0, 32'(BASE + 40), 32'h0, "after_abort");

        // Random single-port traffic
        for (int t = 0; t < 40; t++) begin
            pb = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            data = $urandom;
            case ($urandom_range(0, 5))
                0, 1, 2: addr = 32'(BASE) + 4 * $urandom_range(0, DEP - 1);
                3:       addr = 32'(BASE) + 4 * $urandom_range(0, DEP - 1) + $urandom_range(1, 3);
                4:       addr = $urandom_range(0, BASE - 1);
                default: addr = 32'(BASE + 4 * DEP) + $urandom_range(0, 5000);
            endcase
            do_txn(pb, we, addr, data, $sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
